// File: rtl/uart_rx_ack.sv
// uart_rx_ack: 8N1 serial receiver with a one-entry byte buffer and a per-byte acknowledge pulse.
// Optional even-parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ack #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int ACK_CYCLES   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_in,
    input  logic         data_ready,
    input  logic         overrun_clr,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         ack,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy,
    output logic [2:0]   state_rx
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        ACK       = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_CYCLES - 1);

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [N-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            ack_q, ack_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            rxs, free, load, set_ovr, bad;

    assign rxs  = sync_q[1];
    assign free = !valid_q || data_ready;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign bad = perr_q;

    // parity error flag, latched at the parity sample and cleared at the next frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end
`else
    assign bad = 1'b0;
`endif

    // two-flop synchroniser on the raw serial line
    always_comb begin
        sync_d = {sync_q[0], rx_in};
    end

    // frame sequencing, bit sampling, buffer load and overrun decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ack_cnt_d = '0;
        ferr_d    = 1'b0;
        load      = 1'b0;
        set_ovr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_RX_PARITY_EN
                perr_d = 1'b0;
`endif
                if (!rxs) state_d = START;
            end
            START: begin
                cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
                bit_d = '0;
                if (cnt_q == HALF) state_d = rxs ? IDLE : DATA;
            end
            DATA: begin
                cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
                if (cnt_q == FULL) begin
                    shift_d[bit_q] = rxs;
                    bit_d          = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == LAST_BIT) state_d = PARITY;
`else
                    if (bit_q == LAST_BIT) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
                if (cnt_q == FULL) begin
                    perr_d  = (^shift_q) ^ rxs;
                    state_d = STOP;
                end
            end
`else
            PARITY: state_d = IDLE;
`endif
            STOP: begin
                cnt_d = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
                if (cnt_q == FULL) begin
                    if (!rxs || bad) begin
                        ferr_d  = 1'b1;
                        state_d = rxs ? IDLE : WAIT_IDLE;
                    end else if (free) begin
                        load    = 1'b1;
                        state_d = ACK;
                    end else begin
                        set_ovr = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ACK: begin
                ack_cnt_d = ack_cnt_q + 1'b1;
                if (ack_cnt_q == ACK_LAST) state_d = IDLE;
            end
            WAIT_IDLE: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        data_d  = load ? shift_q : data_q;
        valid_d = load || (valid_q && !data_ready);
        ovr_d   = set_ovr || (ovr_q && !overrun_clr);
        ack_d   = (state_d == ACK);
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_q     <= '0;
            ack_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ack_cnt_q <= ack_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign ack        = ack_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
    assign state_rx   = state_q;

endmodule

// File: tb/tb_uart_rx_ack.sv
// tb_uart_rx_ack: directed checks of uart_rx_ack with CLKS_PER_BIT=8, ACK_CYCLES=4, N=8.
module tb_uart_rx_ack;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       data_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, ack, frame_err, overrun, busy;
    logic [2:0] state_rx;

    int passes = 0;
    int checks = 0;
    int ack_pulses = 0;
    int ferr_cycles = 0;
    int valid_low = 0;
    logic ack_prev = 1'b0;
    int a0, f0, v0;

    uart_rx_ack #(.N(8), .CLKS_PER_BIT(8), .ACK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .data_ready(data_ready),
        .overrun_clr(overrun_clr), .data_out(data_out), .data_valid(data_valid),
        .ack(ack), .frame_err(frame_err), .overrun(overrun), .busy(busy),
        .state_rx(state_rx)
    );

    always #5 clk = ~clk;

    // event counters sampled away from the active edge
    always @(negedge clk) begin
        if (ack && !ack_prev) ack_pulses++;
        ack_prev = ack;
        if (frame_err) ferr_cycles++;
        if (!data_valid) valid_low++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bitt(input logic b);
        rx_in = b;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic head(input logic [7:0] d, input logic p);
        bitt(1'b0);
        for (int i = 0; i < 8; i++) bitt(d[i]);
`ifdef UART_RX_PARITY_EN
        bitt(p);
`else
        if (p === 1'bx) rx_in = 1'b1;
`endif
    endtask

    task automatic frame_p(input logic [7:0] d, input logic p);
        head(d, p);
        bitt(1'b1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d);
        frame_p(d, ^d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state_rx, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        a0 = ack_pulses;
        f0 = ferr_cycles;
        head(8'hA5, 1'b0);
        rx_in = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("a5_stop_state", state_rx, 4);
        chk("a5_valid_pre", data_valid, 0);
        @(negedge clk);
        chk("a5_valid", data_valid, 1);
        chk("a5_data", data_out, 8'hA5);
        chk("a5_ack_first", ack, 1);
        chk("a5_state_ack", state_rx, 5);
        repeat (3) @(negedge clk);
        chk("a5_ack_last", ack, 1);
        @(negedge clk);
        chk("a5_ack_off", ack, 0);
        chk("a5_state_idle", state_rx, 0);
        chk("a5_ack_pulses", ack_pulses - a0, 1);
        chk("a5_no_ferr", ferr_cycles - f0, 0);
        @(posedge clk);
        #1;

        bitt(1'b0);
        bitt(1'b0);
        bitt(1'b0);
        chk("mid_state_data", state_rx, 2);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        rx_in = 1'b1;
        #1;
        chk("mid_rst_state", state_rx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_data", data_out, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        frame(8'h3C);
        chk("3c_valid", data_valid, 1);
        chk("3c_data", data_out, 8'h3C);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        chk("3c_consumed", data_valid, 0);
        chk("3c_data_hold", data_out, 8'h3C);

        a0 = ack_pulses;
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("glitch_start", state_rx, 1);
        repeat (4) @(negedge clk);
        chk("glitch_idle", state_rx, 0);
        chk("glitch_valid", data_valid, 0);
        chk("glitch_no_ack", ack_pulses - a0, 0);
        @(posedge clk);
        #1;

        a0 = ack_pulses;
        f0 = ferr_cycles;
        head(8'h55, 1'b0);
        rx_in = 1'b0;
        repeat (48) @(posedge clk);
        #1;
        chk("brk_state", state_rx, 6);
        chk("brk_ferr_once", ferr_cycles - f0, 1);
        chk("brk_no_ack", ack_pulses - a0, 0);
        chk("brk_valid", data_valid, 0);
        chk("brk_data", data_out, 8'h3C);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("brk_still_wait", state_rx, 6);
        @(negedge clk);
        chk("brk_idle", state_rx, 0);
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;

        a0 = ack_pulses;
        frame(8'h11);
        chk("ov1_valid", data_valid, 1);
        chk("ov1_data", data_out, 8'h11);
        chk("ov1_ovr", overrun, 0);
        frame(8'h22);
        chk("ov2_data", data_out, 8'h11);
        chk("ov2_ovr", overrun, 1);
        chk("ov2_valid", data_valid, 1);
        chk("ov2_one_ack", ack_pulses - a0, 1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        chk("ov_clr", overrun, 0);
        v0 = valid_low;
        head(8'h22, 1'b0);
        rx_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        chk("bb_data", data_out, 8'h22);
        chk("bb_valid", data_valid, 1);
        chk("bb_ack", ack, 1);
        chk("bb_ovr", overrun, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("bb_no_gap", valid_low - v0, 0);
        chk("bb_acks", ack_pulses - a0, 2);

`ifdef UART_RX_PARITY_EN
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        a0 = ack_pulses;
        f0 = ferr_cycles;
        frame_p(8'h07, 1'b1);
        chk("par_ok_valid", data_valid, 1);
        chk("par_ok_data", data_out, 8'h07);
        chk("par_ok_ack", ack_pulses - a0, 1);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        frame_p(8'h07, 1'b0);
        chk("par_bad_ferr", ferr_cycles - f0, 1);
        chk("par_bad_ack", ack_pulses - a0, 1);
        chk("par_bad_valid", data_valid, 0);
        chk("par_bad_state", state_rx, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
